x_mem_arbiter: RTL and testbench

- Shares the single activation (x) memory port between two requesters.
- Requester 0 is the loader, which preloads the input image and reads back results. Requester 1 is the compute engine, which reads and writes x during layers and store_x phases.
- Registered grant, burst locking, round-robin priority on conflict, and a burst-length cap so neither side starves the other.
- Sits between the compute engine / testbench loader and the x memory model; the memory model is unchanged.

---
 rtl/x_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_x_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_mem_arbiter.sv
// x_mem_arbiter: shares the single x (activation) memory port between the
// loader (requester 0) and the compute engine (requester 1).
//
// Handshake: reqN asks for ownership; gntN is registered and decoded from the
// state register. While gntN is high an access is (rqN | wqN) in that cycle.
// lastN marks the final access of a burst. Read data returns on rvalidN one
// cycle after the granted rqN, with rdata shared between both requesters.
module x_mem_arbiter #(
  parameter int X_ADDR_LEN = 10,
  parameter int X_DATA_LEN = 1,
  parameter int X_SEL_LEN  = 2,
  parameter int MAX_BURST  = 1024,
  parameter int CNT_LEN    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  last0,
  input  logic                  last1,
  input  logic                  rq0,
  input  logic                  rq1,
  input  logic                  wq0,
  input  logic                  wq1,
  input  logic [X_ADDR_LEN-1:0] addr0,
  input  logic [X_ADDR_LEN-1:0] addr1,
  input  logic [X_SEL_LEN-1:0]  sel0,
  input  logic [X_SEL_LEN-1:0]  sel1,
  input  logic [X_DATA_LEN-1:0] wdata0,
  input  logic [X_DATA_LEN-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [X_DATA_LEN-1:0] rdata,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic [X_SEL_LEN-1:0]  x_sel,
  output logic                  x_rq,
  output logic                  x_wq,
  output logic [X_DATA_LEN-1:0] x_wdata,
  input  logic [X_DATA_LEN-1:0] x_rdata,
  output logic                  proto_err,
  output logic [1:0]            dbg_state
);

  localparam logic [CNT_LEN-1:0] MAX_CNT = CNT_LEN'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;         // 0: requester 0 wins the next tie
  logic [CNT_LEN-1:0]   cnt_q, cnt_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;
  logic                 proto_err_q, proto_err_d;

  logic                  own_any;
  logic                  own_req, oth_req, own_rq, own_wq, own_last;
  logic [X_ADDR_LEN-1:0] own_addr;
  logic [X_SEL_LEN-1:0]  own_sel;
  logic [X_DATA_LEN-1:0] own_wdata;
  logic                  access, cap_hit, rel;
  logic [CNT_LEN-1:0]    cnt_inc;

  // Grant decode and combinational pass-through of the owner's port to memory.
  always_comb begin
    gnt0      = (state_q == OWN0);
    gnt1      = (state_q == OWN1);
    own_any   = gnt0 | gnt1;
    own_req   = gnt1 ? req1   : req0;
    oth_req   = gnt1 ? req0   : req1;
    own_rq    = gnt1 ? rq1    : rq0;
    own_wq    = gnt1 ? wq1    : wq0;
    own_last  = gnt1 ? last1  : last0;
    own_addr  = gnt1 ? addr1  : addr0;
    own_sel   = gnt1 ? sel1   : sel0;
    own_wdata = gnt1 ? wdata1 : wdata0;
    // A write beats a simultaneous read so memory never sees both strobes.
    x_rq      = own_any & own_rq & ~own_wq;
    x_wq      = own_any & own_wq;
    x_addr    = own_any ? own_addr  : '0;
    x_sel     = own_any ? own_sel   : '0;
    x_wdata   = own_any ? own_wdata : '0;
  end

  // Next-state: arbitration in IDLE, burst tracking and release while owned.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    access      = own_any & (own_rq | own_wq);
    // Saturate at the cap so an uncontested stream never wraps the counter.
    cnt_inc     = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + CNT_LEN'(1);
    cap_hit     = access & (cnt_inc == MAX_CNT) & oth_req;
    rel         = (access & own_last) | ~own_req | cap_hit;
    rvalid0_d   = gnt0 & rq0 & ~wq0;
    rvalid1_d   = gnt1 & rq1 & ~wq1;
    proto_err_d = proto_err_q | (access & own_rq & own_wq);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = ptr_q ? OWN1 : OWN0;
          ptr_d   = ~ptr_q;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (rel) begin
          cnt_d = '0;
          ptr_d = gnt0;  // favour the other requester next time
          // Hand over directly when the other side is waiting: no IDLE bubble.
          if (oth_req) state_d = gnt0 ? OWN1 : OWN0;
          else         state_d = IDLE;
        end else if (access) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset drops any grant and pending read at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = x_rdata;
  assign proto_err = proto_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_x_mem_arbiter.sv
// Testbench for x_mem_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase, all cross-checked every cycle against a
// behavioural ownership model.
module tb_x_mem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 1;
  localparam int SW   = 2;
  localparam int MAXB = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0, req1, last0, last1, rq0, rq1, wq0, wq1;
  logic [AW-1:0] addr0, addr1;
  logic [SW-1:0] sel0, sel1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, x_rq, x_wq, proto_err;
  logic [DW-1:0] rdata, x_wdata, x_rdata;
  logic [AW-1:0] x_addr;
  logic [SW-1:0] x_sel;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  x_mem_arbiter #(
    .X_ADDR_LEN(AW), .X_DATA_LEN(DW), .X_SEL_LEN(SW), .MAX_BURST(MAXB), .CNT_LEN(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .last0(last0), .last1(last1),
    .rq0(rq0), .rq1(rq1), .wq0(wq0), .wq1(wq1),
    .addr0(addr0), .addr1(addr1), .sel0(sel0), .sel1(sel1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .x_addr(x_addr), .x_sel(x_sel), .x_rq(x_rq), .x_wq(x_wq), .x_wdata(x_wdata),
    .x_rdata(x_rdata), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // Memory environment: unwritten locations hold a fixed hash pattern.
  function automatic logic mem_init(int s, int a);
    int h;
    h = a * 7 + s * 3 + 1;
    return ^h;
  endfunction

  bit wr_flag [4][1024];
  bit wr_val  [4][1024];
  always @(posedge clk) begin
    if (x_rq) x_rdata <= wr_flag[x_sel][x_addr] ? wr_val[x_sel][x_addr] : mem_init(int'(x_sel), int'(x_addr));
    if (x_wq) begin
      wr_flag[x_sel][x_addr] <= 1'b1;
      wr_val[x_sel][x_addr]  <= x_wdata[0];
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 nobody, 0 loader, 1 compute. fav: who wins the next tie.
  int m_own, m_cnt, m_fav;
  bit m_rv0, m_rv1, m_rdata, m_perr;
  bit ref_mem [4][1024];

  function automatic logic f_req(int n);  return n == 1 ? req1 : req0;   endfunction
  function automatic logic f_rq(int n);   return n == 1 ? rq1 : rq0;     endfunction
  function automatic logic f_wq(int n);   return n == 1 ? wq1 : wq0;     endfunction
  function automatic logic f_last(int n); return n == 1 ? last1 : last0; endfunction
  function automatic logic [AW-1:0] f_addr(int n); return n == 1 ? addr1 : addr0; endfunction
  function automatic logic [SW-1:0] f_sel(int n);  return n == 1 ? sel1 : sel0;   endfunction
  function automatic logic [DW-1:0] f_wd(int n);   return n == 1 ? wdata1 : wdata0; endfunction

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_fav = 0;
    m_rv0 = 0; m_rv1 = 0; m_perr = 0;
  endtask

  // Compare every DUT output with what the model says for this cycle.
  task automatic model_check();
    bit o;
    o = (m_own >= 0);
    check1("gnt0", gnt0, m_own == 0);
    check1("gnt1", gnt1, m_own == 1);
    check1("rvalid0", rvalid0, m_rv0);
    check1("rvalid1", rvalid1, m_rv1);
    if (m_rv0 || m_rv1) check1("rdata", rdata[0], m_rdata);
    check1("proto_err", proto_err, m_perr);
    check1("x_rq", x_rq, o && f_rq(m_own) && !f_wq(m_own));
    check1("x_wq", x_wq, o && f_wq(m_own));
    checkw("x_addr", 32'(x_addr), o ? 32'(f_addr(m_own)) : 32'd0);
    checkw("x_sel", 32'(x_sel), o ? 32'(f_sel(m_own)) : 32'd0);
    check1("x_wdata", x_wdata[0], o ? f_wd(m_own) : 1'b0);
  endtask

  // Advance the model across one rising edge using the inputs of this cycle.
  task automatic model_step();
    int  oth;
    bit  acc, rel;
    m_rv0 = 0; m_rv1 = 0;
    if (m_own < 0) begin
      if (req0 && req1) begin
        m_own = m_fav;
        m_fav = 1 - m_own;
      end else if (req0) m_own = 0;
      else if (req1) m_own = 1;
      m_cnt = 0;
    end else begin
      oth = 1 - m_own;
      acc = f_rq(m_own) || f_wq(m_own);
      if (f_rq(m_own) && f_wq(m_own)) m_perr = 1;
      if (f_wq(m_own)) ref_mem[f_sel(m_own)][f_addr(m_own)] = f_wd(m_own);
      else if (f_rq(m_own)) begin
        if (m_own == 0) m_rv0 = 1; else m_rv1 = 1;
        m_rdata = ref_mem[f_sel(m_own)][f_addr(m_own)];
      end
      if (acc) m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
      rel = (acc && f_last(m_own)) || !f_req(m_own) || (acc && m_cnt == MAXB && f_req(oth));
      if (rel) begin
        m_fav = oth;
        m_cnt = 0;
        m_own = f_req(oth) ? oth : -1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after a negedge; tick checks mid-cycle and returns at the next negedge.
  task automatic tick();
    #2;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; last0 = 0; last1 = 0;
    rq0 = 0; rq1 = 0; wq0 = 0; wq1 = 0;
    addr0 = '0; addr1 = '0; sel0 = '0; sel1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // ---------------- directed vector table ----------------
  // {req0 req1 rq0 wq0 last0 rq1 wq1 last1} _ {gnt0 gnt1 x_rq x_wq rvalid0 rvalid1 proto_err}
  typedef struct packed {
    logic r0, r1, rq0, wq0, l0, rq1, wq1, l1;
    logic g0, g1, xrq, xwq, rv0, rv1, perr;
  } vec_t;
  vec_t tbl [15];

  int timeout_hit = 0;
  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 1024; a++) ref_mem[s][a] = mem_init(s, a);

    // Reset state with the loader hammering its strobes: nothing reaches memory.
    clear_inputs();
    model_reset();
    req0 = 1; rq0 = 1; wq0 = 1; addr0 = 10'h3a5; sel0 = 2'd3; wdata0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check1("rst_gnt0", gnt0, 0);
    check1("rst_gnt1", gnt1, 0);
    check1("rst_rvalid0", rvalid0, 0);
    check1("rst_rvalid1", rvalid1, 0);
    check1("rst_proto_err", proto_err, 0);
    check1("rst_x_rq", x_rq, 0);
    check1("rst_x_wq", x_wq, 0);
    checkw("rst_x_addr", 32'(x_addr), 0);
    checkw("rst_x_sel", 32'(x_sel), 0);
    check1("rst_x_wdata", x_wdata[0], 0);
    do_reset();

    // Tie-break, no-bubble handover, sticky proto_err, ignored lone last.
    tbl[0]  = 15'b11000000_0000000;
    tbl[1]  = 15'b11010110_1001000;  // non-granted rq1&wq1 must not raise proto_err
    tbl[2]  = 15'b11010000_1001000;
    tbl[3]  = 15'b11100000_1010000;
    tbl[4]  = 15'b11011000_1001100;  // 4th access with last0
    tbl[5]  = 15'b01000100_0110000;  // gnt1 immediately, no IDLE bubble
    tbl[6]  = 15'b01000110_0101010;  // write wins over read
    tbl[7]  = 15'b01000000_0100001;
    tbl[8]  = 15'b00000000_0100001;
    tbl[9]  = 15'b11000110_0000001;  // conflict again: loader wins
    tbl[10] = 15'b11100000_1010001;
    tbl[11] = 15'b01000000_1000101;
    tbl[12] = 15'b01000001_0100001;  // last1 without strobe is ignored
    tbl[13] = 15'b01000101_0110001;
    tbl[14] = 15'b00000000_0000011;
    for (int i = 0; i < 15; i++) begin
      {req0, req1, rq0, wq0, last0, rq1, wq1, last1} = {tbl[i].r0, tbl[i].r1, tbl[i].rq0,
        tbl[i].wq0, tbl[i].l0, tbl[i].rq1, tbl[i].wq1, tbl[i].l1};
      addr0 = AW'(10 + i); addr1 = AW'(20 + i); wdata0 = 1'b1; wdata1 = 1'b0;
      #1;
      check1($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].g0);
      check1($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].g1);
      check1($sformatf("tbl%0d_x_rq", i), x_rq, tbl[i].xrq);
      check1($sformatf("tbl%0d_x_wq", i), x_wq, tbl[i].xwq);
      check1($sformatf("tbl%0d_rvalid0", i), rvalid0, tbl[i].rv0);
      check1($sformatf("tbl%0d_rvalid1", i), rvalid1, tbl[i].rv1);
      check1($sformatf("tbl%0d_proto_err", i), proto_err, tbl[i].perr);
      tick();
    end

    // Loader preload: 784 writes in one burst.
    do_reset();
    req0 = 1;
    #1 check1("ld_gnt0_c0", gnt0, 0);
    tick();
    check1("ld_gnt0_c1", gnt0, 1);
    pulses = 0;
    for (int a = 0; a < 784; a++) begin
      wq0 = 1; addr0 = AW'(a); wdata0 = DW'($urandom_range(0, 1)); last0 = (a == 783);
      #1 if (x_wq) pulses++;
      tick();
    end
    wq0 = 0; last0 = 0;
    check1("ld_gnt0_after", gnt0, 0);
    checkw("ld_state_idle", 32'(dbg_state), 0);
    checkw("ld_wq_pulses", pulses, 784);
    req0 = 0;
    tick();

    // Read latency: compute writes 1 at addr 5, reads it back.
    do_reset();
    req1 = 1;
    tick();
    check1("rd_gnt1", gnt1, 1);
    wq1 = 1; addr1 = 10'd5; sel1 = 2'd0; wdata1 = 1'b1;
    tick();
    wq1 = 0; rq1 = 1;
    tick();
    rq1 = 0;
    check1("rd_rvalid1", rvalid1, 1);
    check1("rd_rdata", rdata[0], 1);
    check1("rd_rvalid0", rvalid0, 0);
    tick();
    check1("rd_rvalid1_once", rvalid1, 0);

    // Burst cap under contention: handover after the 8th access.
    do_reset();
    req1 = 1;
    tick();
    req0 = 1;
    for (int i = 0; i < 8; i++) begin
      rq1 = 1; addr1 = AW'(i);
      #1 check1($sformatf("cap_gnt1_%0d", i), gnt1, 1);
      tick();
    end
    check1("cap_gnt1_drop", gnt1, 0);
    check1("cap_gnt0_rise", gnt0, 1);
    clear_inputs();
    tick();
    tick();

    // Cap without contention: 20 reads under one grant, release once req0 rises.
    do_reset();
    req1 = 1;
    tick();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      rq1 = 1; addr1 = AW'(100 + i);
      #1 if (gnt1 && x_rq) pulses++;
      tick();
    end
    checkw("nocap_reads", pulses, 20);
    req0 = 1; rq1 = 1;
    tick();
    check1("sat_gnt1_drop", gnt1, 0);
    check1("sat_gnt0_rise", gnt0, 1);
    clear_inputs();
    tick();
    tick();

    // Async reset in the cycle after a granted read.
    do_reset();
    req1 = 1;
    tick();
    rq1 = 1; addr1 = 10'd7;
    tick();
    check1("mr_rvalid1_pre", rvalid1, 1);
    rst = 0;
    #1;
    check1("mr_gnt0", gnt0, 0);
    check1("mr_gnt1", gnt1, 0);
    check1("mr_rvalid0", rvalid0, 0);
    check1("mr_rvalid1", rvalid1, 0);
    check1("mr_x_rq", x_rq, 0);
    check1("mr_x_wq", x_wq, 0);
    model_reset();
    rq1 = 0;
    @(negedge clk);
    rst = 1;
    tick();
    check1("mr_gnt1_after", gnt1, 1);
    tick();

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      rq0 = 1'($urandom_range(0, 1));
      rq1 = 1'($urandom_range(0, 1));
      wq0 = ($urandom_range(0, 3) == 0);
      wq1 = ($urandom_range(0, 3) == 0);
      if (wq0 && $urandom_range(0, 15) != 0) rq0 = 0;
      if (wq1 && $urandom_range(0, 15) != 0) rq1 = 0;
      last0 = ($urandom_range(0, 11) == 0);
      last1 = ($urandom_range(0, 11) == 0);
      addr0 = AW'($urandom_range(0, 1023)); addr1 = AW'($urandom_range(0, 1023));
      sel0 = SW'($urandom_range(0, 3));     sel1 = SW'($urandom_range(0, 3));
      wdata0 = DW'($urandom_range(0, 1));   wdata1 = DW'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
